rvh_mmu_ptw_mshr: RTL

Multi-entry miss-status holding register between the TLB miss ports and the page-table walker (PTW). It tracks up to ENTRY_COUNT outstanding translations and merges secondary misses to the same {ASID, VPN} onto one walk. Each PTW response is broadcast with a requester mask so every waiting TLB port is woken. Outstanding work can be cancelled with an sfence-style flush.

---
 rtl/rvh_mmu_ptw_mshr_if.sv | 59 +++++
 rtl/rvh_mmu_ptw_mshr.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rvh_mmu_ptw_mshr_if.sv
// rvh_mmu_ptw_mshr_if: handshake bundle between the TLB miss ports, the MSHR
// and the page-table walker.
//   tlb_miss_req_*  : per-port miss requests (flattened, port i at slice i)
//   ptw_req_*       : walk request toward the PTW
//   ptw_resp_*      : walk completion from the PTW
//   tlb_resp_*      : wake-up broadcast back to the TLB ports
//   flush_i         : sfence-style cancel of all outstanding misses
//   exist_inflight_req_o : any request present or any entry busy
// Modport master is the environment (TLB + PTW side); slave is the MSHR.
interface rvh_mmu_ptw_mshr_if #(
    parameter int unsigned ALLOC_WIDTH    = 2,
    parameter int unsigned VPN_WIDTH      = 27,
    parameter int unsigned ASID_WIDTH     = 16,
    parameter int unsigned TRANS_ID_WIDTH = 3
);
    logic [ALLOC_WIDTH-1:0]            tlb_miss_req_vld_i;
    logic [2*ALLOC_WIDTH-1:0]          tlb_miss_req_access_type_i;
    logic [ASID_WIDTH*ALLOC_WIDTH-1:0] tlb_miss_req_asid_i;
    logic [VPN_WIDTH*ALLOC_WIDTH-1:0]  tlb_miss_req_vpn_i;
    logic [ALLOC_WIDTH-1:0]            tlb_miss_req_rdy_o;

    logic                              ptw_req_vld_o;
    logic [TRANS_ID_WIDTH-1:0]         ptw_req_trans_id_o;
    logic [ASID_WIDTH-1:0]             ptw_req_asid_o;
    logic [VPN_WIDTH-1:0]              ptw_req_vpn_o;
    logic [1:0]                        ptw_req_access_type_o;
    logic                              ptw_req_rdy_i;

    logic                              ptw_resp_vld_i;
    logic [TRANS_ID_WIDTH-1:0]         ptw_resp_trans_id_i;

    logic                              tlb_resp_vld_o;
    logic [ALLOC_WIDTH-1:0]            tlb_resp_req_mask_o;
    logic [ASID_WIDTH-1:0]             tlb_resp_asid_o;
    logic [VPN_WIDTH-1:0]              tlb_resp_vpn_o;

    logic                              flush_i;
    logic                              exist_inflight_req_o;

    modport master (
        output tlb_miss_req_vld_i, tlb_miss_req_access_type_i,
               tlb_miss_req_asid_i, tlb_miss_req_vpn_i,
               ptw_req_rdy_i, ptw_resp_vld_i, ptw_resp_trans_id_i, flush_i,
        input  tlb_miss_req_rdy_o, ptw_req_vld_o, ptw_req_trans_id_o,
               ptw_req_asid_o, ptw_req_vpn_o, ptw_req_access_type_o,
               tlb_resp_vld_o, tlb_resp_req_mask_o, tlb_resp_asid_o,
               tlb_resp_vpn_o, exist_inflight_req_o
    );

    modport slave (
        input  tlb_miss_req_vld_i, tlb_miss_req_access_type_i,
               tlb_miss_req_asid_i, tlb_miss_req_vpn_i,
               ptw_req_rdy_i, ptw_resp_vld_i, ptw_resp_trans_id_i, flush_i,
        output tlb_miss_req_rdy_o, ptw_req_vld_o, ptw_req_trans_id_o,
               ptw_req_asid_o, ptw_req_vpn_o, ptw_req_access_type_o,
               tlb_resp_vld_o, tlb_resp_req_mask_o, tlb_resp_asid_o,
               tlb_resp_vpn_o, exist_inflight_req_o
    );
endinterface

// File: rtl/rvh_mmu_ptw_mshr.sv
// rvh_mmu_ptw_mshr: miss-status holding registers between the TLB miss ports
// and the page-table walker. Tracks up to ENTRY_COUNT walks, merges secondary
// misses on {asid, vpn}, broadcasts each completion with a requester mask and
// supports flush (WAIT entries dropped, INFLIGHT entries marked killed).
// Ports: clk, rstn (synchronous, active-low), bus (rvh_mmu_ptw_mshr_if.slave).
module rvh_mmu_ptw_mshr #(
    parameter int unsigned ALLOC_WIDTH    = 2,
    parameter int unsigned ENTRY_COUNT    = 4,
    parameter int unsigned VPN_WIDTH      = 27,
    parameter int unsigned ASID_WIDTH     = 16,
    parameter int unsigned TRANS_ID_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    rvh_mmu_ptw_mshr_if.slave     bus
);
    localparam int unsigned EIW = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1;
    localparam int unsigned PIW = (ALLOC_WIDTH > 1) ? $clog2(ALLOC_WIDTH) : 1;

    typedef enum logic [1:0] {
        E_FREE     = 2'd0,
        E_WAIT     = 2'd1,
        E_INFLIGHT = 2'd2
    } ent_state_e;

    ent_state_e             state_q  [ENTRY_COUNT];
    logic                   killed_q [ENTRY_COUNT];
    logic [ASID_WIDTH-1:0]  asid_q   [ENTRY_COUNT];
    logic [VPN_WIDTH-1:0]   vpn_q    [ENTRY_COUNT];
    logic [1:0]             at_q     [ENTRY_COUNT];
    logic [ALLOC_WIDTH-1:0] mask_q   [ENTRY_COUNT];

    logic [ASID_WIDTH-1:0]  p_asid    [ALLOC_WIDTH];
    logic [VPN_WIDTH-1:0]   p_vpn     [ALLOC_WIDTH];
    logic [1:0]             p_at      [ALLOC_WIDTH];
    logic [ENTRY_COUNT-1:0] match_vec [ALLOC_WIDTH];
    logic [ALLOC_WIDTH-1:0] port_match;
    logic [ALLOC_WIDTH-1:0] merge_bits [ENTRY_COUNT];
    logic [ALLOC_WIDTH-1:0] rdy;

    logic           resp_hit;
    logic [EIW-1:0] resp_idx;
    logic           free_found;
    logic [EIW-1:0] free_idx;
    logic           wait_found;
    logic [EIW-1:0] wait_idx;
    logic           alloc_found;
    logic [PIW-1:0] alloc_port;
    logic           alloc_en;
    logic           ptw_fire;
    logic           any_busy;

    // Match, allocation, issue and response decode from registered state.
    always_comb begin
        resp_idx = bus.ptw_resp_trans_id_i[EIW-1:0];
        resp_hit = bus.ptw_resp_vld_i
                && (32'(bus.ptw_resp_trans_id_i) < ENTRY_COUNT)
                && (state_q[resp_idx] == E_INFLIGHT);

        free_found = 1'b0;
        free_idx   = '0;
        wait_found = 1'b0;
        wait_idx   = '0;
        any_busy   = 1'b0;
        // Descending scan so the lowest index wins.
        for (int e = ENTRY_COUNT - 1; e >= 0; e--) begin
            if (state_q[e] == E_FREE) begin
                free_found = 1'b1;
                free_idx   = EIW'(e);
            end else begin
                any_busy = 1'b1;
            end
            if (state_q[e] == E_WAIT) begin
                wait_found = 1'b1;
                wait_idx   = EIW'(e);
            end
        end

        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            p_asid[i]    = bus.tlb_miss_req_asid_i[i*ASID_WIDTH +: ASID_WIDTH];
            p_vpn[i]     = bus.tlb_miss_req_vpn_i[i*VPN_WIDTH +: VPN_WIDTH];
            p_at[i]      = bus.tlb_miss_req_access_type_i[i*2 +: 2];
            match_vec[i] = '0;
            for (int e = 0; e < ENTRY_COUNT; e++) begin
                match_vec[i][e] = (state_q[e] != E_FREE) && !killed_q[e]
                               && (asid_q[e] == p_asid[i]) && (vpn_q[e] == p_vpn[i]);
            end
            port_match[i] = |match_vec[i];
        end

        alloc_found = 1'b0;
        alloc_port  = '0;
        for (int i = ALLOC_WIDTH - 1; i >= 0; i--) begin
            if (bus.tlb_miss_req_vld_i[i] && !port_match[i]) begin
                alloc_found = 1'b1;
                alloc_port  = PIW'(i);
            end
        end
        alloc_en = alloc_found && free_found && !bus.flush_i;

        // Same-key losers of allocation simply stall: only alloc_port is granted.
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            rdy[i] = 1'b0;
            if (!bus.flush_i && bus.tlb_miss_req_vld_i[i]) begin
                if (port_match[i]) begin
                    rdy[i] = !(resp_hit && match_vec[i][resp_idx]);
                end else if (alloc_en && (alloc_port == PIW'(i))) begin
                    rdy[i] = 1'b1;
                end
            end
        end

        for (int e = 0; e < ENTRY_COUNT; e++) begin
            merge_bits[e] = '0;
            for (int i = 0; i < ALLOC_WIDTH; i++) begin
                merge_bits[e][i] = rdy[i] && match_vec[i][e];
            end
        end

        bus.tlb_miss_req_rdy_o    = rdy;
        bus.ptw_req_vld_o         = wait_found && !bus.flush_i;
        bus.ptw_req_trans_id_o    = TRANS_ID_WIDTH'(wait_idx);
        bus.ptw_req_asid_o        = asid_q[wait_idx];
        bus.ptw_req_vpn_o         = vpn_q[wait_idx];
        bus.ptw_req_access_type_o = at_q[wait_idx];
        ptw_fire                  = bus.ptw_req_vld_o && bus.ptw_req_rdy_i;

        bus.tlb_resp_vld_o      = resp_hit;
        bus.tlb_resp_req_mask_o = (resp_hit && !killed_q[resp_idx]) ? mask_q[resp_idx] : '0;
        bus.tlb_resp_asid_o     = resp_hit ? asid_q[resp_idx] : '0;
        bus.tlb_resp_vpn_o      = resp_hit ? vpn_q[resp_idx] : '0;

        bus.exist_inflight_req_o = (|bus.tlb_miss_req_vld_i) || any_busy;
    end

    // Per-entry state machine; a response frees an entry even during flush.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int e = 0; e < ENTRY_COUNT; e++) begin
                state_q[e]  <= E_FREE;
                killed_q[e] <= 1'b0;
                asid_q[e]   <= '0;
                vpn_q[e]    <= '0;
                at_q[e]     <= '0;
                mask_q[e]   <= '0;
            end
        end else begin
            for (int e = 0; e < ENTRY_COUNT; e++) begin
                mask_q[e] <= mask_q[e] | merge_bits[e];
                case (state_q[e])
                    E_FREE: begin
                        if (alloc_en && (free_idx == EIW'(e))) begin
                            state_q[e]  <= E_WAIT;
                            killed_q[e] <= 1'b0;
                            asid_q[e]   <= p_asid[alloc_port];
                            vpn_q[e]    <= p_vpn[alloc_port];
                            at_q[e]     <= p_at[alloc_port];
                            mask_q[e]   <= ALLOC_WIDTH'(1) << alloc_port;
                        end
                    end
                    E_WAIT: begin
                        if (bus.flush_i) begin
                            state_q[e] <= E_FREE;
                        end else if (ptw_fire && (wait_idx == EIW'(e))) begin
                            state_q[e] <= E_INFLIGHT;
                        end
                    end
                    E_INFLIGHT: begin
                        if (resp_hit && (resp_idx == EIW'(e))) begin
                            state_q[e]  <= E_FREE;
                            killed_q[e] <= 1'b0;
                        end else if (bus.flush_i) begin
                            killed_q[e] <= 1'b1;
                        end
                    end
                    default: state_q[e] <= E_FREE;
                endcase
            end
        end
    end
endmodule
